// File: rtl/rv_pkg.sv
// Shared rvcpu definitions: datapath widths, reset PC and the {pc, instr} packet
// passed from fetch to decode.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/rv_fetch_skid.sv
// One-entry {pc, instr} holding register used by fetch to park a ROM word while decode stalls.
// Priority: flush, then load, then release.
module rv_fetch_skid
    import rv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_release,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [ILEN-1:0] i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [ILEN-1:0] o_instr
);
    fetch_pkt_t r_pkt;
    logic       r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pkt   <= '{pc: RESET_PC, instr: NOP};
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pkt   <= '{pc: i_pc, instr: i_instr};
        end else if (i_release) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pkt.pc;
    assign o_instr = r_pkt.instr;
endmodule

// File: rtl/rv_fetch.sv
// Instruction fetch: owns the PC, drives the sync ROM one word per cycle, hides its 1-cycle
// latency with a skid entry, and hands {pc, instr} to decode under valid/ready.
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        misalign_err
);
    import rv_pkg::*;

    // Handshake: a word moves to decode in any cycle with out_valid & out_ready; while
    // out_valid is high and out_ready low, out_pc/out_instr hold unchanged.
    logic        r_inflight;
    logic [31:0] r_pc;
    logic [31:0] r_inflight_pc;
    logic        r_misalign;

    logic        w_stall;
    logic        w_issue;
    logic        w_skid_valid;
    logic        w_skid_next;
    logic        w_skid_load;
    logic        w_skid_release;
    logic [31:0] w_skid_pc;
    logic [31:0] w_skid_instr;
    logic [31:0] w_pc_issue;

    assign w_stall        = out_valid & ~out_ready;
    assign w_skid_release = w_skid_valid & out_ready;
    // The ROM word parks when decode stalls on it, or slides in behind a skid word leaving now.
    assign w_skid_load    = r_inflight & ((w_skid_valid & out_ready) | (~w_skid_valid & w_stall));
    assign w_skid_next    = ~redirect_valid & (w_skid_load | (w_skid_valid & ~w_skid_release));
    assign w_issue        = redirect_valid | (~halt_req & ~w_stall & ~w_skid_next);

    assign w_pc_issue = redirect_valid ? {redirect_pc[31:2], 2'b00} : r_pc;
    // Upper word-address bits alias within the ROM but are passed through untouched.
    assign imem_addr  = {2'b00, w_pc_issue[31:ADDR_W+2], w_pc_issue[ADDR_W+1:2]};

    assign out_valid    = ~redirect_valid & (w_skid_valid | r_inflight);
    assign out_pc       = w_skid_valid ? w_skid_pc    : r_inflight_pc;
    assign out_instr    = w_skid_valid ? w_skid_instr : imem_q;
    assign misalign_err = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_misalign    <= 1'b0;
        end else begin
            r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
            if (w_issue) begin
                r_pc          <= w_pc_issue + 32'd4;
                r_inflight    <= 1'b1;
                r_inflight_pc <= w_pc_issue;
            end else begin
                r_inflight <= 1'b0;
            end
        end
    end

    rv_fetch_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_skid_load),
        .i_release (w_skid_release),
        .i_flush   (redirect_valid),
        .i_pc      (r_inflight_pc),
        .i_instr   (imem_q),
        .o_valid   (w_skid_valid),
        .o_pc      (w_skid_pc),
        .o_instr   (w_skid_instr)
    );
endmodule
